// File: rtl/gzip_out_framer.sv
// gzip_out_framer: drains the gzip output FIFO (rden -> data next cycle) into a
// valid/ready stream. The newest word is held back until the end of the stream
// is known, so the final word can carry m_last. An eof strobe and a per-stream
// word count are also produced.
module gzip_out_framer #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned BUF_DEPTH     = 4,
   parameter int unsigned BUF_DEPTH_LOG = 2,
   parameter int unsigned CNT_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rden,
   input  logic                  gzip_done,
   input  logic                  restart,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  eof_pulse,
   output logic                  stream_done,
   output logic [CNT_WIDTH-1:0]  word_count
);

   localparam int unsigned CW      = BUF_DEPTH_LOG + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(BUF_DEPTH);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [DATA_WIDTH-1:0]   buf_mem [BUF_DEPTH];
   logic [BUF_DEPTH_LOG-1:0] wr_ptr;
   logic [BUF_DEPTH_LOG-1:0] rd_ptr;
   logic [CW-1:0]           count;
   logic [CW:0]             occ;
   logic                    inflight;
   logic                    done_seen;
   logic                    rd_arm;
   logic                    accept;
   logic                    rearm;

   // Buffered plus in-flight words; reads stop once this reaches the depth.
   assign occ = {1'b0, count} + (CW+1)'(inflight);

   // rd_arm keeps rden low during reset and the first cycle after release.
   assign fifo_rden = rd_arm && (state == ST_RUN) && !fifo_empty && (occ < DEPTH_L);

   assign m_data      = m_valid ? buf_mem[rd_ptr] : '0;
   assign stream_done = (state == ST_DONE);

   // Next-state, stream handshake and hold-back decode.
   always_comb begin
      state_nxt = state;
      m_valid   = 1'b0;
      m_last    = 1'b0;
      accept    = 1'b0;
      rearm     = 1'b0;
      unique case (state)
         ST_RUN: begin
            m_valid = (count >= CW'(2));
            accept  = m_valid && m_ready;
            if (done_seen && fifo_empty && !inflight && !fifo_rden)
               state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            m_valid = (count != '0);
            m_last  = (count == CW'(1));
            accept  = m_valid && m_ready;
            if ((count == '0) || (accept && m_last))
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (restart) begin
               state_nxt = ST_RUN;
               rearm     = 1'b1;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RUN;
      else        state <= state_nxt;
   end

   // Buffer bookkeeping, done latch, eof strobe and word counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         inflight   <= 1'b0;
         done_seen  <= 1'b0;
         rd_arm     <= 1'b0;
         eof_pulse  <= 1'b0;
         word_count <= '0;
      end else begin
         rd_arm   <= 1'b1;
         inflight <= fifo_rden;
         if (inflight) wr_ptr <= wr_ptr + BUF_DEPTH_LOG'(1);
         if (accept)   rd_ptr <= rd_ptr + BUF_DEPTH_LOG'(1);
         unique case ({inflight, accept})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (rearm)          done_seen <= 1'b0;
         else if (gzip_done) done_seen <= 1'b1;
         eof_pulse <= (state_nxt == ST_DONE) && (state != ST_DONE);
         if (rearm)       word_count <= '0;
         else if (accept) word_count <= word_count + CNT_WIDTH'(1);
      end
   end

   // Buffer storage: FIFO data lands the cycle after rden.
   always_ff @(posedge clk) begin
      if (inflight) buf_mem[wr_ptr] <= fifo_dout;
   end

endmodule
